// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   state_e       : sequencer states (RUN, MEM_WAIT, HALT)
//   stage_ctrl_t  : bundle of PC / pipeline-register enable, flush and redirect controls
//   CTL_*         : canned control bundles for the common pipeline actions
package pipe_ctrl_pkg;

  localparam int unsigned DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // Every stage advances, nothing squashed.
  localparam stage_ctrl_t CTL_ADVANCE = '{pc_en: 1'b1, pc_redirect: 1'b0,
                                          if_id_en: 1'b1, if_id_flush: 1'b0,
                                          id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                          ex_mem_en: 1'b1, mem_wb_flush: 1'b0};

  // Whole pipe held; only a bubble is fed into MEM/WB.
  localparam stage_ctrl_t CTL_FROZEN  = '{pc_en: 1'b0, pc_redirect: 1'b0,
                                          if_id_en: 1'b0, if_id_flush: 1'b0,
                                          id_ex_en: 1'b0, id_ex_flush: 1'b0,
                                          ex_mem_en: 1'b0, mem_wb_flush: 1'b1};

  // Held in reset: nothing written, every flush asserted.
  localparam stage_ctrl_t CTL_RESET   = '{pc_en: 1'b0, pc_redirect: 1'b0,
                                          if_id_en: 1'b0, if_id_flush: 1'b1,
                                          id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                          ex_mem_en: 1'b0, mem_wb_flush: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination
// of a load currently in EX. x0 is never a hazard.
//   rs1/rs2, use_rs1/use_rs2 : ID source registers and their read flags
//   rd, mem_read             : EX destination and load flag
//   hazard_c                 : combinational hazard flag
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  mem_read,
  output logic                  hazard_c
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = use_rs1 && (rs1 == rd);
  assign hit_rs2  = use_rs2 && (rs2 == rd);
  assign hazard_c = mem_read && (rd != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, taken-branch
// redirects, dmem wait-state freezes and a watchdog that halts on a stuck access.
// Inputs : clk, rst (async active-low), ID_rs1/ID_rs2/ID_use_rs1/ID_use_rs2,
//          EX_rd/EX_mem_read/EX_br_taken, MEM_dmem_req, dmem_ready
// Outputs: pc_en, pc_redirect, IF_ID_en/flush, ID_EX_en/flush, EX_MEM_en,
//          MEM_WB_flush, halted (all combinational from state + inputs)
// Optional: HAZ_PERF_CNT_EN adds perf_stall_cyc / perf_flush_cnt counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned MAX_WAIT   = 255,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_use_rs1,
  input  logic                  ID_use_rs2,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_mem_read,
  input  logic                  EX_br_taken,
  input  logic                  MEM_dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  pc_redirect,
  output logic                  IF_ID_en,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_en,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_en,
  output logic                  MEM_WB_flush,
  output logic                  halted
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN      = RUN;
  localparam logic [1:0] ST_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] ST_HALT     = HALT;

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait_cnt;
  stage_ctrl_t       ctl;
  logic              load_use;
  logic              dmem_stall;

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use (
    .rs1     (ID_rs1),
    .rs2     (ID_rs2),
    .use_rs1 (ID_use_rs1),
    .use_rs2 (ID_use_rs2),
    .rd      (EX_rd),
    .mem_read(EX_mem_read),
    .hazard_c(load_use)
  );

  assign dmem_stall = MEM_dmem_req && !dmem_ready;

  // State and watchdog counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
    end
  end

  // Next state, watchdog and stage controls; reset overrides the controls asynchronously.
  always_comb begin
    ctl           = CTL_ADVANCE;
    next_state    = state;
    next_wait_cnt = wait_cnt;
    unique case (state)
      ST_RUN: begin
        if (dmem_stall) begin
          ctl           = CTL_FROZEN;
          next_state    = ST_MEM_WAIT;
          next_wait_cnt = WAIT_W'(1);
        end else if (EX_br_taken) begin
          // The squashed ID instruction makes any concurrent load-use moot.
          ctl.pc_redirect = 1'b1;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end else if (load_use) begin
          ctl.pc_en       = 1'b0;
          ctl.if_id_en    = 1'b0;
          ctl.id_ex_flush = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // Branch and load-use are not evaluated here; the release cycle just advances.
        if (dmem_ready) begin
          next_state    = ST_RUN;
          next_wait_cnt = '0;
        end else begin
          ctl = CTL_FROZEN;
          if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
            next_state = ST_HALT;
          end else begin
            next_wait_cnt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_HALT: begin
        ctl = CTL_FROZEN;
      end
      default: begin
        next_state    = ST_RUN;
        next_wait_cnt = '0;
      end
    endcase
    if (!rst) begin
      ctl = CTL_RESET;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign pc_redirect  = ctl.pc_redirect;
  assign IF_ID_en     = ctl.if_id_en;
  assign IF_ID_flush  = ctl.if_id_flush;
  assign ID_EX_en     = ctl.id_ex_en;
  assign ID_EX_flush  = ctl.id_ex_flush;
  assign EX_MEM_en    = ctl.ex_mem_en;
  assign MEM_WB_flush = ctl.mem_wb_flush;
  assign halted       = rst && (state == ST_HALT);

`ifdef HAZ_PERF_CNT_EN
  // Stall cycles exclude the halted freeze; both counters wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!ctl.pc_en && (state != ST_HALT)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'(1);
      end
      if (ctl.pc_redirect) begin
        perf_flush_cnt <= perf_flush_cnt + 32'(1);
      end
    end
  end
`endif

endmodule
